// File: rtl/uart_pkg.sv
// uart_pkg: shared divisor helpers and config type for the UART baud tick generator
//   calc_div_int  : integer sample divisor minus one for a given clock/baud/oversample
//   calc_div_frac : fractional remainder of that divisor in 1/2^fw cycle units
//   div_cfg_t     : packed {div_int, div_frac} divisor pair at the default widths
package uart_pkg;

    localparam int CFG_DIV_W  = 16;
    localparam int CFG_FRAC_W = 4;

    typedef struct packed {
        logic [CFG_DIV_W-1:0]  div_int;
        logic [CFG_FRAC_W-1:0] div_frac;
    } div_cfg_t;

    function automatic longint calc_div_int(input longint sys, input longint baud, input longint os);
        return sys / (baud * os) - 1;
    endfunction

    function automatic longint calc_div_frac(input longint sys, input longint baud, input longint os,
                                             input int fw);
        return ((sys << fw) / (baud * os)) % (longint'(1) << fw);
    endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: control, config handshake and tick strobes of the baud tick generator
//   en, resync          : generator enable and bit-phase restart pulse (master -> slave)
//   cfg_valid/cfg_ready : divisor offer handshake
//   cfg_div_int/frac    : offered sample period minus one / fractional extra period
//   sample/mid/bit_tick : one-cycle strobes (slave -> master)
interface baud_tick_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic              resync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIV_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              sample_tick;
    logic              mid_tick;
    logic              bit_tick;

    modport master (
        output en, resync, cfg_valid, cfg_div_int, cfg_div_frac,
        input  cfg_ready, sample_tick, mid_tick, bit_tick
    );

    modport slave (
        input  en, resync, cfg_valid, cfg_div_int, cfg_div_frac,
        output cfg_ready, sample_tick, mid_tick, bit_tick
    );
endinterface

// File: rtl/frac_accum.sv
// frac_accum: fractional divisor accumulator producing a one-period extra-cycle request
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : clear accumulator and pending extra cycle
//   i_step     : add i_frac at a sample tick
//   i_frac     : fractional divisor in 1/2^FRAC_W cycle units
//   o_extra    : carry of the last step; lengthens the next sample period by one cycle
// Only present when BAUD_FRAC_EN is defined.
`ifdef BAUD_FRAC_EN
module frac_accum #(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_step,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_extra
);
    logic [FRAC_W-1:0] r_acc;
    logic              r_extra;

    // Every step rewrites the carry, so the extra cycle lasts exactly one period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_extra <= 1'b0;
        end else if (i_clr) begin
            r_acc   <= '0;
            r_extra <= 1'b0;
        end else if (i_step) begin
            {r_extra, r_acc} <= {1'b0, r_acc} + {1'b0, i_frac};
        end
    end

    assign o_extra = r_extra;
endmodule
`endif

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable oversampling tick generator for UART RX/TX
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : baud_tick_gen_if.slave
//                en/resync in, cfg_valid/cfg_div_int/cfg_div_frac in, cfg_ready out,
//                sample_tick/mid_tick/bit_tick out
// Macro BAUD_FRAC_EN: adds the fractional accumulator (and the FRAC_W parameter);
// without it cfg_div_frac is ignored and every sample period is div_int+1 cycles.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned SYS_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 38400,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int          DIV_W      = 16
`ifdef BAUD_FRAC_EN
    ,
    parameter int          FRAC_W     = 4
`endif
) (
    input logic            clk,
    input logic            rst_n,
    baud_tick_gen_if.slave bus
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0] DEF_DIV_INT =
        DIV_W'(calc_div_int(longint'(SYS_FREQ), longint'(BAUD_RATE), longint'(OVERSAMPLE)));

    // cnt is one bit wider than the divisor so a maximal div_int plus the extra cycle fits.
    logic [DIV_W:0]    r_cnt;
    logic [OS_W-1:0]   r_os;
    logic              r_pend;
    logic [DIV_W-1:0]  r_div_int;
    logic [DIV_W-1:0]  r_sh_int;
    logic              w_clr;
    logic              w_tick;
    logic              w_extra;
    logic              w_accept;
    logic              w_apply;
    logic [DIV_W:0]    w_term;

    assign w_clr    = !bus.en || bus.resync;
    assign w_term   = {1'b0, r_div_int} + {{DIV_W{1'b0}}, w_extra};
    // resync and en=0 suppress the tick even if cnt has reached term.
    assign w_tick   = !w_clr && r_cnt == w_term;
    assign w_accept = bus.cfg_valid && !r_pend;
    // A pending divisor lands on a period boundary: a tick, a resync or an idle cycle.
    assign w_apply  = r_pend && (w_tick || w_clr);

`ifdef BAUD_FRAC_EN
    localparam logic [FRAC_W-1:0] DEF_DIV_FRAC =
        FRAC_W'(calc_div_frac(longint'(SYS_FREQ), longint'(BAUD_RATE), longint'(OVERSAMPLE), FRAC_W));

    logic [FRAC_W-1:0] r_div_frac;
    logic [FRAC_W-1:0] r_sh_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_frac <= DEF_DIV_FRAC;
            r_sh_frac  <= '0;
        end else begin
            if (w_accept) r_sh_frac <= bus.cfg_div_frac;
            if (w_apply) r_div_frac <= r_sh_frac;
        end
    end

    // The tick that applies a new divisor still accumulates the old fraction.
    frac_accum #(.FRAC_W(FRAC_W)) u_frac_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_step (w_tick),
        .i_frac (r_div_frac),
        .o_extra(w_extra)
    );
`else
    assign w_extra = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_os      <= '0;
            r_pend    <= 1'b0;
            r_div_int <= DEF_DIV_INT;
            r_sh_int  <= '0;
        end else begin
            r_cnt  <= (w_clr || w_tick) ? '0 : r_cnt + (DIV_W + 1)'(1);
            r_os   <= w_clr ? '0 : !w_tick ? r_os : (r_os == OS_LAST) ? '0 : r_os + OS_W'(1);
            r_pend <= w_accept ? 1'b1 : w_apply ? 1'b0 : r_pend;
            if (w_accept) r_sh_int <= bus.cfg_div_int;
            if (w_apply) r_div_int <= r_sh_int;
        end
    end

    assign bus.cfg_ready   = !r_pend;
    assign bus.sample_tick = w_tick;
    assign bus.mid_tick    = w_tick && r_os == OS_MID;
    assign bus.bit_tick    = w_tick && r_os == OS_LAST;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: randomized self-checking bench for baud_tick_gen against an event-time model
module tb_baud_tick_gen;
    localparam int OS       = 16;
    localparam int FW       = 4;
    localparam int DEF_INT  = 161;
    localparam int DEF_FRAC = 12;
`ifdef BAUD_FRAC_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    baud_tick_gen_if #(.DIV_W(16), .FRAC_W(FW)) bus ();

    baud_tick_gen dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    longint next_tick = 0;
    longint en_start = 0;
    int     m_div = DEF_INT;
    int     m_frac = DEF_FRAC;
    int     m_sh_div = 0;
    int     m_sh_frac = 0;
    int     m_ticks = 0;
    int     m_fsum = 0;
    bit     m_pend = 1'b0;
    bit     rec = 1'b0;
    longint tick_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs after the edge, compare at the falling edge, then advance the model.
    // The model tracks the absolute cycle of the next expected sample tick.
    task automatic step(input bit r, input bit e, input bit rs, input bit v, input int di, input int fr);
        bit t;
        int carry;
        int s;
        @(posedge clk);
        #1;
        rst_n            = r;
        bus.en           = e;
        bus.resync       = rs;
        bus.cfg_valid    = v;
        bus.cfg_div_int  = 16'(di);
        bus.cfg_div_frac = FW'(fr);
        @(negedge clk);
        cyc++;
        if (!r) begin
            check("rst_sample_tick", bus.sample_tick, 0);
            check("rst_mid_tick", bus.mid_tick, 0);
            check("rst_bit_tick", bus.bit_tick, 0);
            check("rst_cfg_ready", bus.cfg_ready, 1);
            m_div = DEF_INT;
            m_frac = DEF_FRAC;
            m_pend = 1'b0;
            m_ticks = 0;
            m_fsum = 0;
            next_tick = cyc + 1 + DEF_INT;
        end else begin
            t = e && !rs && cyc == next_tick;
            check("sample_tick", bus.sample_tick, t);
            check("mid_tick", bus.mid_tick, t && (m_ticks % OS) == OS / 2 - 1);
            check("bit_tick", bus.bit_tick, t && (m_ticks % OS) == OS - 1);
            check("cfg_ready", bus.cfg_ready, !m_pend);
            if (rec && bus.sample_tick) tick_q.push_back(cyc);
            carry = 0;
            if (t) begin
                if (FE) begin
                    s = m_fsum + m_frac;
                    carry = s / (1 << FW);
                    m_fsum = s % (1 << FW);
                end
                m_ticks++;
            end
            if (m_pend && (t || rs || !e)) begin
                m_div = m_sh_div;
                m_frac = m_sh_frac;
                m_pend = 1'b0;
            end else if (v && !m_pend) begin
                m_pend = 1'b1;
                m_sh_div = int'(bus.cfg_div_int);
                m_sh_frac = int'(bus.cfg_div_frac);
            end
            if (!e || rs) begin
                m_ticks = 0;
                m_fsum = 0;
                next_tick = cyc + 1 + m_div;
            end else if (t) begin
                next_tick = cyc + 1 + m_div + carry;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        bus.en = 1'b0;
        bus.resync = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div_int = '0;
        bus.cfg_div_frac = '0;
        repeat (3) step(0, 0, 0, 0, 0, 0);
        // Default divisor: first tick, and sixteen consecutive periods.
        rec = 1'b1;
        en_start = cyc + 1;
        idle(2900);
        rec = 1'b0;
        check("tick_count", (tick_q.size() >= 17) ? 17 : tick_q.size(), 17);
        if (tick_q.size() >= 17) begin
            check("first_tick_delay", tick_q[0] - en_start, DEF_INT);
            check("sixteen_periods", tick_q[16] - tick_q[0], FE ? 2604 : 2592);
        end
        // Mid-period reconfiguration to a 4-cycle period.
        idle(37);
        step(1, 1, 0, 1, 3, 0);
        idle(400);
        // Fastest setting: a tick every enabled cycle.
        step(1, 1, 0, 1, 0, 0);
        idle(100);
        // Back to defaults, then resync at cnt=100 in the tenth sample period.
        repeat (2) step(0, 0, 0, 0, 0, 0);
        idle(9 * 162 + (FE ? 6 : 0) + 100);
        step(1, 1, 1, 0, 0, 0);
        idle(2700);
        // Pending config applied while disabled, then reset mid-period.
        step(1, 1, 0, 1, 5, 3);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        idle(50);
        repeat (2) step(0, 1, 0, 0, 0, 0);
        idle(400);
        // Randomized traffic.
        for (int i = 0; i < 8000; i++) begin
            step($urandom_range(0, 2999) != 0,
                 $urandom_range(0, 99) != 0,
                 $urandom_range(0, 199) == 0,
                 $urandom_range(0, 19) == 0,
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 12)),
                 int'($urandom_range(0, 15)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
